// File: rtl/matrix_bus_pkg.sv
// Shared definitions for the matrix bus subsystem (package mx_pkg).
// Holds bus widths, the register and RAM address map, and the core FSM state type.
// Nothing here has ports. Every other file imports it.
package mx_pkg;

  localparam int DW = 32;
  localparam int AW = 8;

  // Register map
  localparam logic [AW-1:0] A_PUSH    = 8'h00;
  localparam logic [AW-1:0] B_PUSH    = 8'h01;
  localparam logic [AW-1:0] CLEAR     = 8'h02;
  localparam logic [AW-1:0] OPSTART   = 8'h03;
  localparam logic [AW-1:0] INT_EN    = 8'h04;
  localparam logic [AW-1:0] STATUS    = 8'h05;
  localparam logic [AW-1:0] RESULT    = 8'h06;

  // RAM window 0x20..0x7F; results are written back at 0x60..0x63
  localparam logic [AW-1:0] RAM_BASE  = 8'h20;
  localparam logic [AW-1:0] RAM_LAST  = 8'h7F;
  localparam logic [AW-1:0] C_WB_BASE = 8'h60;
  localparam int            RAM_WORDS = 96;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    WB   = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/matrix_bus_if.sv
// External bus of the matrix subsystem. M0 is the only external master.
// Handshake: M0 holds M0_req high to ask for the bus. A transfer takes effect on
// any rising edge where M0_req=1 and the registered M0_grant=1. M0_wr selects
// write (1) or read (0). M_din is combinational read data for the current
// M0_address. M1_grant is visible so observers can see internal write-back.
// Modports: master (drives request/address/data), slave (drives grants/read data).
interface matrix_bus_if;
  logic                   M0_req;
  logic                   M0_wr;
  logic [mx_pkg::AW-1:0]  M0_address;
  logic [mx_pkg::DW-1:0]  M0_dout;
  logic                   M0_grant;
  logic                   M1_grant;
  logic [mx_pkg::DW-1:0]  M_din;

  modport master (
    output M0_req, M0_wr, M0_address, M0_dout,
    input  M0_grant, M1_grant, M_din
  );

  modport slave (
    input  M0_req, M0_wr, M0_address, M0_dout,
    output M0_grant, M1_grant, M_din
  );
endinterface

// File: rtl/matrix_bus_fifo.sv
// mx_fifo: synchronous show-ahead FIFO used for the A and B operand streams.
// Ports: clk, rst_n (async active-low), push/din, pop/dout (dout is the head
// entry), count, full, empty. A push to a full FIFO is dropped. A pop from an
// empty FIFO is ignored. Push and pop may happen in the same cycle.
module mx_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH-1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
      end
      if (do_push && !do_pop)      count <= count + CNT_ONE;
      else if (!do_push && do_pop) count <= count - CNT_ONE;
    end
  end
endmodule

// File: rtl/matrix_bus_top.sv
// matrix_bus_top: two-master bus with a 96-word RAM, control registers and a
// 2x2 matrix-multiply core fed from two operand FIFOs.
// Ports: clk, reset_n (async active-low), bus (matrix_bus_if.slave: M0
// request/address/data in, grants and M_din out), m_interrupt, multi_opdone,
// dbg_state (core FSM state, for observation only).
// Build option: define MATRIX_WB_EN to have the internal master M1 write
// C[0..3] to RAM 0x60..0x63 after each multiply. Without it the core goes
// straight from MAC to DONE and results are only readable through RESULT.
module matrix_bus_top import mx_pkg::*; #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  matrix_bus_if.slave    bus,
  output logic           m_interrupt,
  output logic           multi_opdone,
  output state_t         dbg_state
);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam logic [CW-1:0] START_LEVEL = CW'(8);

  state_t          state, state_nxt;
  logic            m1_req, pop, busy;
  logic            m0_grant, m1_grant;
  logic            bus_act, bus_wr, bus_sel, we;
  logic [AW-1:0]   bus_addr;
  logic [DW-1:0]   bus_wdata, rd_data, rd_latch;
  logic [DW-1:0]   ram [RAM_WORDS];
  logic            in_ram;
  logic [6:0]      ram_idx;
  logic            int_en, opdone;
  logic [1:0]      sel;
  logic [DW-1:0]   c_reg [4];
  logic [DW-1:0]   acc, prod;
  logic [2:0]      mac_cnt;
  logic [1:0]      c_idx, wb_idx;
  logic            a_push, b_push, clear_req, start_req;
  logic [DW-1:0]   a_dout, b_dout;
  logic [CW-1:0]   a_count, b_count;
  logic            a_full, b_full, a_empty, b_empty;

  // ---------------- arbiter: registered grants, M1 wins ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m0_grant <= 1'b0;
      m1_grant <= 1'b0;
    end else if (m1_req) begin
      m1_grant <= 1'b1;
      m0_grant <= 1'b0;
    end else begin
      m1_grant <= 1'b0;
      m0_grant <= bus.M0_req;
    end
  end

  assign bus.M0_grant = m0_grant;
  assign bus.M1_grant = m1_grant;

  // Select the granted master's transfer. M1 only ever writes results.
  always_comb begin
    bus_act   = 1'b0;
    bus_wr    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    if (m1_grant) begin
      bus_act   = 1'b1;
      bus_wr    = 1'b1;
      bus_addr  = C_WB_BASE + AW'(wb_idx);
      bus_wdata = c_reg[wb_idx];
    end else if (m0_grant) begin
      bus_act   = bus.M0_req;
      bus_wr    = bus.M0_wr;
      bus_addr  = bus.M0_address;
      bus_wdata = bus.M0_dout;
    end
  end

  assign bus_sel = m0_grant | m1_grant;
  assign we      = bus_act & bus_wr;
  assign in_ram  = (bus_addr >= RAM_BASE) && (bus_addr <= RAM_LAST);
  assign ram_idx = 7'(bus_addr - RAM_BASE);

  // ---------------- read path ----------------
  always_comb begin
    rd_data = '0;
    if (bus_sel) begin
      if (in_ram) begin
        rd_data = ram[ram_idx];
      end else begin
        case (bus_addr)
          INT_EN:  rd_data = DW'(int_en);
          STATUS:  rd_data = DW'({a_count, b_count, busy, opdone});
          RESULT:  rd_data = c_reg[sel];
          default: rd_data = '0;
        endcase
      end
    end
  end

  assign bus.M_din = rd_data;

  // ---------------- register writes ----------------
  // Pushes are gated on full here too, so a dropped push never reaches a FIFO.
  assign a_push    = we && (bus_addr == A_PUSH) && !a_full;
  assign b_push    = we && (bus_addr == B_PUSH) && !b_full;
  assign clear_req = we && (bus_addr == CLEAR)   && bus_wdata[0];
  assign start_req = we && (bus_addr == OPSTART) && bus_wdata[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RAM_WORDS; i++) ram[i] <= '0;
    end else if (we && in_ram) begin
      ram[ram_idx] <= bus_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      int_en   <= 1'b0;
      sel      <= 2'd0;
      rd_latch <= '0;
      opdone   <= 1'b0;
    end else begin
      if (we && (bus_addr == INT_EN)) int_en <= bus_wdata[0];
      if (we && (bus_addr == RESULT)) sel    <= bus_wdata[1:0];
      // Only M0 reads feed the push staging register.
      if (m0_grant && !m1_grant && bus.M0_req && !bus.M0_wr) rd_latch <= rd_data;
      // Completion has priority over a CLEAR in the same cycle.
      if (state == DONE)  opdone <= 1'b1;
      else if (clear_req) opdone <= 1'b0;
    end
  end

  assign multi_opdone = opdone;
  assign m_interrupt  = opdone & int_en;

  // ---------------- operand FIFOs ----------------
  mx_fifo #(.DEPTH(FIFO_DEPTH), .W(DW)) u_fifo_a (
    .clk(clk), .rst_n(reset_n), .push(a_push), .pop(pop), .din(rd_latch),
    .dout(a_dout), .count(a_count), .full(a_full), .empty(a_empty)
  );

  mx_fifo #(.DEPTH(FIFO_DEPTH), .W(DW)) u_fifo_b (
    .clk(clk), .rst_n(reset_n), .push(b_push), .pop(pop), .din(rd_latch),
    .dout(b_dout), .count(b_count), .full(b_full), .empty(b_empty)
  );

  // ---------------- core FSM ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_req && (a_count >= START_LEVEL) && (b_count >= START_LEVEL))
              state_nxt = MAC;
      MAC:  if (pop && (mac_cnt == 3'd7)) begin
`ifdef MATRIX_WB_EN
              state_nxt = WB;
`else
              state_nxt = DONE;
`endif
            end
      WB:   if (m1_grant && (wb_idx == 2'd3)) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    pop  = (state == MAC) && !a_empty && !b_empty;
`ifdef MATRIX_WB_EN
    m1_req = (state == WB);
`else
    m1_req = 1'b0;
`endif
  end

  assign dbg_state = state;

  // ---------------- MAC datapath ----------------
  // Products pair up: every odd pop closes one C element (a dot product of 2).
  assign prod = a_dout * b_dout;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc     <= '0;
      mac_cnt <= 3'd0;
      c_idx   <= 2'd0;
      wb_idx  <= 2'd0;
      for (int i = 0; i < 4; i++) c_reg[i] <= '0;
    end else begin
      if ((state == IDLE) && (state_nxt == MAC)) begin
        acc     <= '0;
        mac_cnt <= 3'd0;
        c_idx   <= 2'd0;
        wb_idx  <= 2'd0;
      end
      if (pop) begin
        mac_cnt <= mac_cnt + 3'd1;
        if (mac_cnt[0]) begin
          c_reg[c_idx] <= acc + prod;
          acc          <= '0;
          c_idx        <= c_idx + 2'd1;
        end else begin
          acc <= acc + prod;
        end
      end
      if ((state == WB) && m1_grant) wb_idx <= wb_idx + 2'd1;
    end
  end
endmodule

// File: tb/tb_matrix_bus_top.sv
module tb_matrix_bus_top;
  import mx_pkg::*;

  localparam logic [7:0] AD_A_PUSH  = 8'h00;
  localparam logic [7:0] AD_B_PUSH  = 8'h01;
  localparam logic [7:0] AD_CLEAR   = 8'h02;
  localparam logic [7:0] AD_OPSTART = 8'h03;
  localparam logic [7:0] AD_INT_EN  = 8'h04;
  localparam logic [7:0] AD_STATUS  = 8'h05;
  localparam logic [7:0] AD_RESULT  = 8'h06;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  matrix_bus_if bus ();
  logic   m_interrupt, multi_opdone;
  state_t dbg_state;

  matrix_bus_top #(.FIFO_DEPTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave),
    .m_interrupt(m_interrupt), .multi_opdone(multi_opdone), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.M0_wr      = 1'b1;
    bus.M0_address = a;
    bus.M0_dout    = d;
    @(posedge clk);
    #1;
    bus.M0_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.M0_wr      = 1'b0;
    bus.M0_address = a;
    #1 d = bus.M_din;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.M0_grant) break;
    end
    check_val("m0_grant_wait", 32'(bus.M0_grant), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] rd;
  logic [7:0]  a_order [8];
  logic [7:0]  b_order [8];
  logic [31:0] ram_a [4];
  logic [31:0] ram_b [4];
  logic        m1_seen;

  initial begin
    a_order = '{8'h20, 8'h21, 8'h20, 8'h21, 8'h22, 8'h23, 8'h22, 8'h23};
    b_order = '{8'h40, 8'h42, 8'h41, 8'h43, 8'h40, 8'h42, 8'h41, 8'h43};
    ram_a   = '{32'd10, 32'd11, 32'd12, 32'd13};
    ram_b   = '{32'd14, 32'd16, 32'd15, 32'd17};
    m1_seen = 1'b0;

    reset_n        = 1'b0;
    bus.M0_req     = 1'b0;
    bus.M0_wr      = 1'b0;
    bus.M0_address = 8'h00;
    bus.M0_dout    = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_m0_grant", 32'(bus.M0_grant), 32'd0);
    check_val("rst_m1_grant", 32'(bus.M1_grant), 32'd0);
    check_val("rst_m_din", bus.M_din, 32'd0);
    check_val("rst_opdone", 32'(multi_opdone), 32'd0);
    check_val("rst_state", 32'(dbg_state), 32'd0);

    // Grant is registered: still low right after the request rises.
    reset_n    = 1'b1;
    bus.M0_req = 1'b1;
    #1 check_val("grant_lag", 32'(bus.M0_grant), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check_val("m0_grant", 32'(bus.M0_grant), 32'd1);
    check_val("m1_grant_idle", 32'(bus.M1_grant), 32'd0);
    check_val("opdone_idle", 32'(multi_opdone), 32'd0);
    check_val("irq_idle", 32'(m_interrupt), 32'd0);

    // RAM load and readback
    for (int i = 0; i < 4; i++) bus_write(8'h20 + 8'(i), ram_a[i]);
    for (int i = 0; i < 4; i++) bus_write(8'h40 + 8'(i), ram_b[i]);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(ram_a[i]);
      bus_read(8'h20 + 8'(i), rd);
      check_val("ram_a_rd", rd, exp_q.pop_front());
    end
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(ram_b[i]);
      bus_read(8'h40 + 8'(i), rd);
      check_val("ram_b_rd", rd, exp_q.pop_front());
    end
    bus_read(8'h10, rd);
    check_val("unmapped_rd", rd, 32'd0);

    // Fill A with 8, B with only 7; start must be ignored.
    for (int i = 0; i < 8; i++) begin
      bus_read(a_order[i], rd);
      bus_write(AD_A_PUSH, 32'd0);
    end
    for (int i = 0; i < 7; i++) begin
      bus_read(b_order[i], rd);
      bus_write(AD_B_PUSH, 32'd0);
    end
    bus_write(AD_OPSTART, 32'd1);
    bus_read(AD_STATUS, rd);
    check_val("start_ignored", rd, 32'd540);   // A=8<<6 | B=7<<2, idle

    bus_read(b_order[7], rd);
    bus_write(AD_B_PUSH, 32'd0);
    // Extra push to the full A FIFO must be dropped.
    bus_read(8'h7F, rd);
    bus_write(AD_A_PUSH, 32'd0);
    bus_read(AD_STATUS, rd);
    check_val("status_full", rd, 32'd544);     // 8<<6 | 8<<2

    bus_write(AD_OPSTART, 32'd1);
    bus_read(AD_STATUS, rd);
    check_val("status_busy", rd, 32'd546);     // counts 8/8, busy=1

    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.M1_grant) m1_seen = 1'b1;
      if (multi_opdone) break;
    end
    check_val("opdone_set", 32'(multi_opdone), 32'd1);
`ifdef MATRIX_WB_EN
    check_val("m1_pulse", 32'(m1_seen), 32'd1);
`else
    check_val("m1_quiet", 32'(m1_seen), 32'd0);
`endif
    wait_grant();
    check_val("irq_masked", 32'(m_interrupt), 32'd0);
    bus_read(AD_STATUS, rd);
    check_val("status_done", rd, 32'd1);

    // C = [10 11;12 13] x [14 16;15 17]
    exp_q.push_back(32'd305);
    exp_q.push_back(32'd347);
    exp_q.push_back(32'd363);
    exp_q.push_back(32'd413);
    for (int i = 0; i < 4; i++) begin
      bus_write(AD_RESULT, 32'(i));
      bus_read(AD_RESULT, rd);
      check_val("result", rd, exp_q[i]);
    end
`ifdef MATRIX_WB_EN
    for (int i = 0; i < 4; i++) begin
      bus_read(8'h60 + 8'(i), rd);
      check_val("wb_ram", rd, exp_q[i]);
    end
`endif
    exp_q.delete();

    bus_write(AD_INT_EN, 32'd1);
    check_val("irq_on", 32'(m_interrupt), 32'd1);
    bus_read(AD_INT_EN, rd);
    check_val("int_en_rd", rd, 32'd1);
    bus_write(AD_CLEAR, 32'd1);
    check_val("clear_opdone", 32'(multi_opdone), 32'd0);
    check_val("clear_irq", 32'(m_interrupt), 32'd0);

    // Reset with data queued: FIFOs and RAM return to zero.
    bus_read(8'h20, rd);
    bus_write(AD_A_PUSH, 32'd0);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    wait_grant();
    bus_read(AD_STATUS, rd);
    check_val("rst_status", rd, 32'd0);
    bus_read(8'h20, rd);
    check_val("rst_ram", rd, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/matrix_bus_top.md
Name: matrix_bus_top

Overview:
- Bus subsystem with two masters, a word memory and a 2x2 matrix-multiply unit.
- M0 is the external port. M1 is the matrix unit's internal write-back master.
- M0 loads operands into memory, reads them back, pushes them into the A/B operand FIFOs, starts a multiply and reads the results.
- Result availability is flagged on multi_opdone and m_interrupt.

Parameters:
- FIFO_DEPTH, 8, entries per operand FIFO (minimum 8).
- DW, 32, data width.
- AW, 8, address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- M0_req  in  1  M0 bus request.
- M0_wr  in  1  M0 write (1) / read (0).
- M0_address  in  8  M0 word address.
- M0_dout  in  32  M0 write data.
- M0_grant  out  1  M0 owns bus.
- M1_grant  out  1  internal master M1 owns bus.
- M_din  out  32  read-data bus to masters.
- m_interrupt  out  1  operation-done interrupt.
- multi_opdone  out  1  operation-done status.

Behaviour:
- One clock; asynchronous active-low reset.
- Reset clears all registers, memory, FIFOs, grants, flags and M_din to 0.

Arbiter:
- M1 has priority whenever m1_req=1.
- Otherwise M0_grant=M0_req.
- Grants are registered: they change one cycle after a request change.
- Bus transactions from the non-granted master are ignored.

Address map:
- 0x00 A_PUSH (write): push rd_latch into A FIFO.
- 0x01 B_PUSH (write): push rd_latch into B FIFO.
- 0x02 CLEAR (write bit0=1): clear opdone.
- 0x03 OPSTART (write bit0=1): start.
- 0x04 INT_EN (R/W bit0).
- 0x05 STATUS (read): {A count, B count, busy, opdone}.
- 0x06 RESULT: a write sets sel[1:0]; a read returns C[sel].
- 0x20-0x7F: 96-word RAM, synchronous write.
- Unmapped addresses: writes ignored, reads return 0.

Read path:
- M_din is a combinational mux of the granted master's addressed location (RAM / registers / C[sel]), driven every cycle regardless of wr.
- On a granted M0 read cycle (wr=0), rd_latch<=M_din at the clock edge.

FIFOs:
- Push to a full FIFO is dropped; pop from an empty FIFO never occurs.
- Simultaneous push and pop is allowed.

Core FSM:
- IDLE: on OPSTART with both FIFO counts >=8 -> MAC; otherwise the start is ignored.
- MAC: 8 cycles; each cycle pops A and B and does acc+=a*b (32-bit truncated).
  - After every 2nd pop: C[n]<=acc, acc<=0, n++.
  - Produces row-major C00,C01,C10,C11 when A is pushed as rows, each row twice, and B as columns, column pair twice.
- WB: m1_req=1; after M1_grant, write C[0..3] to RAM 0x60..0x63, one per cycle; then release.
- DONE: opdone<=1 -> IDLE.

Flags and boundary cases:
- multi_opdone=opdone; m_interrupt=opdone&INT_EN.
- CLEAR in the same cycle as opdone set: set wins.
- OPSTART while busy: ignored.
- Reset mid-operation: returns to IDLE, FIFOs emptied.

Optional Feature:
- Macro: MATRIX_WB_EN.
- Defined: WB state and M1 write-back to 0x60..0x63 as above.
- Undefined: MAC goes directly to DONE; m1_req and M1_grant stay 0; results only via RESULT.

Decomposition:
- Package mx_pkg: address constants (A_PUSH, B_PUSH, CLEAR, OPSTART, INT_EN, STATUS, RESULT, RAM_BASE, C_WB_BASE), FSM state enum (IDLE, MAC, WB, DONE), DW/AW.
- Sub-module mx_fifo: synchronous FIFO with push, pop, dout, count, full, empty; instantiated twice.

Test Plan:
- Reset, then M0_req=1 -> M0_grant=1 next cycle; M1_grant=0; multi_opdone=0; m_interrupt=0.
- Write 10,11,12,13 to 0x20-0x23 and 14,16,15,17 to 0x40-0x43; read each back -> M_din returns the written value.
- Alternate read/push: A order 0x20,21,20,21,22,23,22,23 via A_PUSH; B order 0x40,42,41,43 twice via B_PUSH -> STATUS counts 8/8.
- OPSTART=1 -> within 20 cycles multi_opdone=1; RESULT sel 0..3 -> 305, 347, 363, 413; with MATRIX_WB_EN, RAM 0x60..0x63 holds the same values and M1_grant pulses.
- INT_EN=1 while opdone -> m_interrupt=1; CLEAR=1 -> both low next cycle.
- OPSTART with FIFOs holding fewer than 8 entries -> ignored (busy stays 0). Push to a full FIFO -> count stays 8.
